// File: rtl/av_recvpacket_pkg.sv
// Shared constants for the UDP receive-descriptor block: register map,
// STATUS/CONTROL bit positions and the descriptor layout.
package av_recvpacket_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int DESC_W             = 144;

  // Avalon-MM word addresses
  localparam logic [3:0] ADDR_STATUS      = 4'd0;
  localparam logic [3:0] ADDR_CONTROL     = 4'd1;
  localparam logic [3:0] ADDR_LENGTH      = 4'd2;
  localparam logic [3:0] ADDR_SRC_PORT    = 4'd3;
  localparam logic [3:0] ADDR_DST_PORT    = 4'd4;
  localparam logic [3:0] ADDR_SRC_IP      = 4'd5;
  localparam logic [3:0] ADDR_SRC_MAC_LSB = 4'd6;
  localparam logic [3:0] ADDR_SRC_MAC_MSB = 4'd7;

  // STATUS bit positions
  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_COUNT_LSB = 2;
  localparam int STAT_COUNT_W   = 5;
  localparam int STAT_OVERFLOW  = 8;
  localparam int STAT_DROPS_LSB = 16;

  // CONTROL bit positions
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_POP    = 1;
  localparam int CTRL_CLEAR  = 2;

  // One received-packet descriptor. The reserved half-word is always stored
  // as zero so it doubles as the zero-extension of the MAC MSB register.
  typedef struct packed {
    logic [15:0] rsvd;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] dst_port;
    logic [15:0] src_port;
    logic [15:0] length;
  } desc_t;

endpackage

// File: rtl/av_recvpacket_desc_fifo.sv
// Descriptor FIFO: power-of-two depth, wrapping pointers, head always visible.
// A push and pop in the same cycle both take effect, even when full.
module recv_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 144,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];

  // Storage array: written at the tail, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/av_recvpacket.sv
// Avalon-MM slave buffering descriptors of received UDP packets, with an
// overflow/drop counter and a level interrupt while descriptors are pending.
module av_recvpacket
  import av_recvpacket_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        rx_packet_valid,
  input  logic [15:0] rx_length_i,
  input  logic [15:0] rx_src_port_i,
  input  logic [15:0] rx_dst_port_i,
  input  logic [31:0] rx_src_IP_i,
  input  logic [47:0] rx_src_MAC_i,
  output logic        irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic          rx_valid_d_reg;
  logic          rx_armed_reg;
  logic          irq_enable_reg;
  logic          overflow_reg;
  logic [15:0]   drop_cnt_reg;
  logic [31:0]   readdata_reg;
  logic          irq_reg;

  logic          push_evt;
  logic          ctrl_wr;
  logic          pop_cmd;
  logic          clear_cmd;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  desc_t         push_desc;
  desc_t         head_desc;
  logic [31:0]   status_word;
  logic [31:0]   rd_mux;

  // A push needs a low-to-high transition seen after reset; a level already
  // high when reset releases is not a new packet, so wait until it drops.
  assign push_evt  = rx_packet_valid & ~rx_valid_d_reg & rx_armed_reg;
  assign ctrl_wr   = write & (address == ADDR_CONTROL);
  assign pop_cmd   = ctrl_wr & writedata[CTRL_POP];
  assign clear_cmd = ctrl_wr & writedata[CTRL_CLEAR];
  assign drop      = push_evt & fifo_full & ~(pop_cmd & ~fifo_empty);

  assign push_desc = '{rsvd:     16'h0,
                       src_mac:  rx_src_MAC_i,
                       src_ip:   rx_src_IP_i,
                       dst_port: rx_dst_port_i,
                       src_port: rx_src_port_i,
                       length:   rx_length_i};

  recv_desc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DESC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_evt),
    .pop   (pop_cmd),
    .din   (push_desc),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head_desc)
  );

  // Edge detector for rx_packet_valid plus the post-reset arming flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid_d_reg <= 1'b0;
      rx_armed_reg   <= 1'b0;
    end else begin
      rx_valid_d_reg <= rx_packet_valid;
      if (!rx_packet_valid) rx_armed_reg <= 1'b1;
    end
  end

  // CONTROL, overflow flag and saturating drop counter; a drop in the same
  // cycle as CLEAR wins, leaving overflow set and one drop counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_enable_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      drop_cnt_reg   <= '0;
    end else begin
      if (ctrl_wr) irq_enable_reg <= writedata[CTRL_IRQ_EN];
      if (clear_cmd) begin
        overflow_reg <= drop;
        drop_cnt_reg <= drop ? 16'd1 : 16'd0;
      end else if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

  // STATUS word assembly.
  always_comb begin
    status_word = '0;
    status_word[STAT_NOT_EMPTY] = ~fifo_empty;
    status_word[STAT_FULL]      = fifo_full;
    status_word[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
    status_word[STAT_OVERFLOW]  = overflow_reg;
    status_word[STAT_DROPS_LSB +: 16] = drop_cnt_reg;
  end

  // Read decode; descriptor registers read zero when nothing is buffered.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATUS:      rd_mux = status_word;
      ADDR_CONTROL:     rd_mux = {31'b0, irq_enable_reg};
      ADDR_LENGTH:      if (!fifo_empty) rd_mux = {16'h0, head_desc.length};
      ADDR_SRC_PORT:    if (!fifo_empty) rd_mux = {16'h0, head_desc.src_port};
      ADDR_DST_PORT:    if (!fifo_empty) rd_mux = {16'h0, head_desc.dst_port};
      ADDR_SRC_IP:      if (!fifo_empty) rd_mux = head_desc.src_ip;
      ADDR_SRC_MAC_LSB: if (!fifo_empty) rd_mux = head_desc.src_mac[31:0];
      ADDR_SRC_MAC_MSB: if (!fifo_empty) rd_mux = {head_desc.rsvd, head_desc.src_mac[47:32]};
      default:          rd_mux = '0;
    endcase
  end

  // Registered read data (held while read is low) and registered interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      if (read) readdata_reg <= rd_mux;
      irq_reg <= irq_enable_reg & ~fifo_empty;
    end
  end

  assign readdata = readdata_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_av_recvpacket.sv
// Directed bench for av_recvpacket: stimulus queues expected read/irq values,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_av_recvpacket;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        rx_packet_valid;
  logic [15:0] rx_length_i;
  logic [15:0] rx_src_port_i;
  logic [15:0] rx_dst_port_i;
  logic [31:0] rx_src_IP_i;
  logic [47:0] rx_src_MAC_i;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  exp_t rd_q[$];
  exp_t irq_q[$];
  exp_t mon_e;
  logic rd_seen  = 1'b0;
  logic irq_seen = 1'b0;
  logic irq_probe;

  always #5 clk = ~clk;

  av_recvpacket #(.FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .address         (address),
    .write           (write),
    .read            (read),
    .writedata       (writedata),
    .readdata        (readdata),
    .rx_packet_valid (rx_packet_valid),
    .rx_length_i     (rx_length_i),
    .rx_src_port_i   (rx_src_port_i),
    .rx_dst_port_i   (rx_dst_port_i),
    .rx_src_IP_i     (rx_src_IP_i),
    .rx_src_MAC_i    (rx_src_MAC_i),
    .irq             (irq)
  );

  // Remember which edges carried a read or an irq probe.
  always @(posedge clk) begin
    rd_seen  <= read & ~reset;
    irq_seen <= irq_probe;
  end

  // Monitor: compare DUT outputs half a cycle after the edge that produced them.
  always @(negedge clk) begin
    if (rd_seen) begin
      vectors++;
      if (rd_q.size() == 0) begin
        miscompares++;
        $display("FAIL read_unexpected: got 0x%08h, no expected value queued", readdata);
      end else begin
        mon_e = rd_q.pop_front();
        if (readdata !== mon_e.value) begin
          miscompares++;
          $display("FAIL %s: readdata got 0x%08h, expected 0x%08h", mon_e.name, readdata, mon_e.value);
        end else
          $display("ok   %s: readdata 0x%08h", mon_e.name, readdata);
      end
    end
    if (irq_seen) begin
      vectors++;
      if (irq_q.size() == 0) begin
        miscompares++;
        $display("FAIL irq_unexpected: got %0b, no expected value queued", irq);
      end else begin
        mon_e = irq_q.pop_front();
        if (irq !== mon_e.value[0]) begin
          miscompares++;
          $display("FAIL %s: irq got %0b, expected %0b", mon_e.name, irq, mon_e.value[0]);
        end else
          $display("ok   %s: irq %0b", mon_e.name, irq);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] ev, input string nm);
    rd_q.push_back('{name: nm, value: ev});
    address = a;
    read    = 1'b1;
    tick();
    read    = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick();
    write     = 1'b0;
  endtask

  task automatic exp_irq(input logic v, input string nm);
    irq_q.push_back('{name: nm, value: {31'b0, v}});
  endtask

  // Packet k: length k, src 0x1000+k, dst 0x2000+k, IP 0x0A000000+k, MAC 0x020000000000+k.
  task automatic set_fields(input int k);
    rx_length_i   = 16'(k);
    rx_src_port_i = 16'h1000 + 16'(k);
    rx_dst_port_i = 16'h2000 + 16'(k);
    rx_src_IP_i   = 32'h0A00_0000 + 32'(k);
    rx_src_MAC_i  = 48'h0200_0000_0000 + 48'(k);
  endtask

  task automatic pkt(input int k);
    set_fields(k);
    rx_packet_valid = 1'b1;
    tick();
    rx_packet_valid = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; address = '0; write = 1'b0; read = 1'b0; writedata = '0;
    rx_packet_valid = 1'b0; irq_probe = 1'b0;
    set_fields(0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    exp_irq(1'b0, "reset_irq"); irq_probe = 1'b1; tick(); irq_probe = 1'b0;
    rd(4'd0, 32'h0, "reset_status");
    rd(4'd1, 32'h0, "reset_control");
    rd(4'd2, 32'h0, "reset_length_empty");

    // Single packet, all descriptor fields
    rx_length_i = 16'h0020; rx_src_port_i = 16'hFDEB; rx_dst_port_i = 16'h0050;
    rx_src_IP_i = 32'hC0A8_0005; rx_src_MAC_i = 48'h74EA_3A85_1BD8;
    rx_packet_valid = 1'b1; tick(); rx_packet_valid = 1'b0; tick();
    rd(4'd0, 32'h0000_0005, "single_status");
    rd(4'd2, 32'h0000_0020, "single_length");
    rd(4'd3, 32'h0000_FDEB, "single_src_port");
    rd(4'd4, 32'h0000_0050, "single_dst_port");
    rd(4'd5, 32'hC0A8_0005, "single_src_ip");
    rd(4'd6, 32'h3A85_1BD8, "single_mac_lsb");
    rd(4'd7, 32'h0000_74EA, "single_mac_msb");
    rd(4'd9, 32'h0, "addr9_reads_zero");
    wr(4'd0, 32'hFFFF_FFFF);
    wr(4'd2, 32'h1234_5678);
    wr(4'd9, 32'hFFFF_FFFF);
    rd(4'd0, 32'h0000_0005, "ro_write_ignored_status");
    rd(4'd2, 32'h0000_0020, "ro_write_ignored_length");
    wr(4'd1, 32'h2);
    rd(4'd0, 32'h0, "pop_to_empty_status");
    rd(4'd6, 32'h0, "empty_mac_lsb_zero");

    // irq: enabled, one packet, then enable+pop
    wr(4'd1, 32'h1);
    set_fields(20);
    rx_packet_valid = 1'b1; irq_probe = 1'b1; exp_irq(1'b0, "irq_low_at_push_edge"); tick();
    rx_packet_valid = 1'b0; exp_irq(1'b1, "irq_high_after_count1"); tick();
    address = 4'd1; writedata = 32'h3; write = 1'b1; exp_irq(1'b1, "irq_high_at_pop_edge"); tick();
    write = 1'b0; exp_irq(1'b0, "irq_low_after_pop"); tick();
    irq_probe = 1'b0;
    rd(4'd1, 32'h1, "control_readback");
    rd(4'd0, 32'h0, "irq_pop_status");
    wr(4'd1, 32'h0);
    rd(4'd1, 32'h0, "control_cleared");

    // Overflow: six packets into depth 4
    for (int k = 1; k <= 6; k++) pkt(k);
    rd(4'd0, 32'h0002_0113, "overflow_status");
    rd(4'd2, 32'h0000_0001, "overflow_head_len");
    rd(4'd5, 32'h0A00_0001, "overflow_head_ip");
    wr(4'd1, 32'h4);
    rd(4'd0, 32'h0000_0013, "clear_status");

    // Full + simultaneous push and pop
    set_fields(7);
    rx_packet_valid = 1'b1; address = 4'd1; writedata = 32'h2; write = 1'b1; tick();
    rx_packet_valid = 1'b0; write = 1'b0; tick();
    rd(4'd0, 32'h0000_0013, "pushpop_full_status");
    rd(4'd2, 32'h0000_0002, "pushpop_head_len");
    for (int k = 0; k < 3; k++) wr(4'd1, 32'h2);
    rd(4'd2, 32'h0000_0007, "pushpop_tail_len");
    rd(4'd3, 32'h0000_1007, "pushpop_tail_src_port");
    rd(4'd7, 32'h0000_0200, "pushpop_tail_mac_msb");
    wr(4'd1, 32'h2);
    rd(4'd0, 32'h0, "drained_status");

    // CLEAR in the same cycle as a dropped push
    for (int k = 8; k <= 11; k++) pkt(k);
    set_fields(12);
    rx_packet_valid = 1'b1; address = 4'd1; writedata = 32'h4; write = 1'b1; tick();
    rx_packet_valid = 1'b0; write = 1'b0; tick();
    rd(4'd0, 32'h0001_0113, "clear_drop_same_cycle");
    rd(4'd2, 32'h0000_0008, "clear_drop_head_len");
    wr(4'd1, 32'h4);
    for (int k = 0; k < 4; k++) wr(4'd1, 32'h2);
    rd(4'd0, 32'h0, "clear_drop_drained");

    // POP on empty; long valid gives one push
    wr(4'd1, 32'h2);
    rd(4'd0, 32'h0, "pop_empty_status");
    set_fields(13);
    rx_packet_valid = 1'b1;
    repeat (10) tick();
    rx_packet_valid = 1'b0;
    tick();
    rd(4'd0, 32'h0000_0005, "long_valid_one_push");
    rd(4'd2, 32'h0000_000D, "long_valid_len");
    wr(4'd1, 32'h2);

    // Reset mid-operation with valid held high
    wr(4'd1, 32'h1);
    for (int k = 14; k <= 16; k++) pkt(k);
    rd(4'd0, 32'h0000_000D, "pre_reset_status");
    set_fields(17);
    rx_packet_valid = 1'b1; reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    rd(4'd0, 32'h0, "post_reset_status");
    rd(4'd1, 32'h0, "post_reset_control");
    exp_irq(1'b0, "post_reset_irq"); irq_probe = 1'b1; tick(); irq_probe = 1'b0;
    rx_packet_valid = 1'b0;
    tick();
    pkt(18);
    rd(4'd0, 32'h0000_0005, "post_reset_new_push");
    rd(4'd2, 32'h0000_0012, "post_reset_new_len");

    repeat (3) tick();
    while (rd_q.size() != 0) begin
      mon_e = rd_q.pop_front();
      vectors++; miscompares++;
      $display("FAIL %s: read never observed, expected 0x%08h", mon_e.name, mon_e.value);
    end
    while (irq_q.size() != 0) begin
      mon_e = irq_q.pop_front();
      vectors++; miscompares++;
      $display("FAIL %s: irq never observed, expected %0b", mon_e.name, mon_e.value[0]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/av_recvpacket.md
AV_RECVPACKET -- requirements
Module: av_recvpacket

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of received-packet descriptors buffered; power of two, 2..16.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 address  in  4  Avalon-MM word address.
REQ-005 write  in  1  Avalon-MM write strobe.
REQ-006 read  in  1  Avalon-MM read strobe.
REQ-007 writedata  in  32  Avalon-MM write data.
REQ-008 readdata  out  32  Avalon-MM read data, registered.
REQ-009 rx_packet_valid  in  1  level from UDP receiver; a rising edge announces one received packet.
REQ-010 rx_length_i  in  16  received UDP payload length, bytes.
REQ-011 rx_src_port_i  in  16  source UDP port.
REQ-012 rx_dst_port_i  in  16  destination UDP port.
REQ-013 rx_src_IP_i  in  32  source IPv4 address.
REQ-014 rx_src_MAC_i  in  48  source MAC address.
REQ-015 irq  out  1  interrupt request to CPU, level.

Function
REQ-016 Push event SHALL be rx_packet_valid high while its one-cycle-delayed copy is low; all rx_*_i fields SHALL be sampled in that same cycle into a 144-bit descriptor.
REQ-017 Descriptors SHALL be stored in a FIFO_DEPTH-entry FIFO; the head entry SHALL be presented on the register map.
REQ-018 Register map (word address): 0 STATUS RO, 1 CONTROL RW, 2 LENGTH RO, 3 SRC_PORT RO, 4 DST_PORT RO, 5 SRC_IP RO, 6 SRC_MAC_LSB RO (MAC[31:0]), 7 SRC_MAC_MSB RO (MAC[47:32] in bits 15:0); 16-bit fields zero-extended.
REQ-019 STATUS: bit0 not_empty, bit1 full, bits[6:2] count, bit8 overflow sticky, bits[31:16] drop counter.
REQ-020 CONTROL write: bit0 irq_enable (stored); bit1 POP command (self-clearing, not stored); bit2 CLEAR (self-clearing) zeroes overflow and drop counter. CONTROL read returns {31'b0, irq_enable}.
REQ-021 Registers 2..7 SHALL read 0 when FIFO empty.
REQ-022 Read latency SHALL be exactly 1 cycle: readdata updates on the edge after read is sampled; addresses 8..15 return 0; readdata holds its value when read is low.
REQ-023 Writes to RO addresses and to 8..15 SHALL be ignored.
REQ-024 POP when empty SHALL be ignored; POP when non-empty SHALL discard the head, count decrements next cycle.
REQ-025 Push when not full SHALL store descriptor; count increments next cycle.
REQ-026 Push and POP in same cycle SHALL both take effect (count unchanged), including when full: no drop.
REQ-027 Push when full without POP SHALL discard the descriptor, set overflow, increment drop counter, saturating at 0xFFFF.
REQ-028 CLEAR and a dropped push in the same cycle: overflow SHALL end set, drop counter SHALL end at 1.
REQ-029 Read-pointer and write-pointer SHALL wrap modulo FIFO_DEPTH.
REQ-030 irq SHALL equal registered (irq_enable AND not_empty), asserting one cycle after the causing condition.

Reset
REQ-031 While reset high: FIFO empty, pointers 0, count 0, overflow 0, drop counter 0, irq_enable 0, readdata 0, irq 0, edge-detect register 0.
REQ-032 Reset mid-operation SHALL discard all buffered descriptors; a rx_packet_valid already high at reset release SHALL NOT generate a push.

Structure
REQ-033 Shared package SHALL hold register address constants, STATUS/CONTROL bit positions, descriptor width (144) and default FIFO_DEPTH.
REQ-034 Descriptor storage SHALL be one sub-module, recv_desc_fifo (push, pop, full, empty, count, head data); register decode stays in av_recvpacket.

Verification
REQ-035 Single packet: rx_length 0x0020, src_port 0xFDEB, IP 0xC0A80005, MAC 0x74EA3A851BD8 -> STATUS reads 0x00000005, regs 2..7 read 0x20, 0xFDEB, dst, 0xC0A80005, 0x3A851BD8, 0x000074EA.
REQ-036 irq: CONTROL=1 then one packet -> irq high one cycle after count=1; write CONTROL=3 -> FIFO empty, irq low next cycle.
REQ-037 Overflow: 6 packets, depth 4, no pops -> STATUS full=1, count=4, overflow=1, drops=2; head is packet 1; CONTROL bit2 -> drops 0, overflow 0.
REQ-038 Full + simultaneous push/POP -> count stays 4, drops 0, new head is packet 2, tail is new packet.
REQ-039 POP on empty and read of address 9 -> count 0, readdata 0; rx_packet_valid held high 10 cycles -> exactly one push.
REQ-040 Reset asserted with 3 entries and rx_packet_valid high; released with valid still high -> STATUS reads 0.
